// File: rtl/alu_arb_ctrl.sv
// ---------------------------------------------------------------------------
// alu_arb_ctrl
//   Round-robin arbiter and sequencer that shares one combinational ALU
//   between two requesters. It accepts one command at a time, drives the
//   ALU from registered operands for one cycle, captures the result and the
//   zero flag, and returns them on the originating requester's response port.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   req{0,1}_valid/_ready             command handshake per requester
//   req{0,1}_opcode/_op_0/_op_1       one-hot opcode and operands
//   rsp{0,1}_valid/_ready             response handshake per requester
//   rsp{0,1}_result/_zero             captured ALU result and zero flag
//   alu_opcode/_op_0/_op_1            to the shared ALU (zero outside EXEC)
//   alu_result, alu_zero_f            from the shared ALU
//   busy                              high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module alu_arb_ctrl #(
    parameter int DW  = 8,
    parameter int OPW = 7
) (
    input  logic           clk,
    input  logic           resetn,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_opcode,
    input  logic [DW-1:0]  req0_op_0,
    input  logic [DW-1:0]  req0_op_1,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_opcode,
    input  logic [DW-1:0]  req1_op_0,
    input  logic [DW-1:0]  req1_op_1,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_result,
    output logic           rsp0_zero,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_result,
    output logic           rsp1_zero,

    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_op_0,
    output logic [DW-1:0]  alu_op_1,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero_f,

    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_id_q, last_id_d;
    logic           owner_q, owner_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [DW-1:0]  op_0_q, op_0_d;
    logic [DW-1:0]  op_1_q, op_1_d;
    logic [DW-1:0]  rsp0_result_q, rsp0_result_d;
    logic           rsp0_zero_q, rsp0_zero_d;
    logic [DW-1:0]  rsp1_result_q, rsp1_result_d;
    logic           rsp1_zero_q, rsp1_zero_d;

    logic           grant0;
    logic           grant1;
    logic           owner_rsp_ready;

    // Round-robin: a lone requester always wins; on a tie the requester that
    // was not served last wins. last_id resets to 1 so requester 0 wins first.
    assign grant0 = req0_valid && (!req1_valid || last_id_q);
    assign grant1 = req1_valid && (!req0_valid || !last_id_q);

    // Only the owner's response ready completes the transaction.
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: every register has an explicit reset value; an aborted operation
    // must leave no stale opcode, operand or response behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            last_id_q     <= 1'b1;
            owner_q       <= 1'b0;
            opcode_q      <= '0;
            op_0_q        <= '0;
            op_1_q        <= '0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_id_q     <= last_id_d;
            owner_q       <= owner_d;
            opcode_q      <= opcode_d;
            op_0_q        <= op_0_d;
            op_1_q        <= op_1_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a hold default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        last_id_d     = last_id_q;
        owner_d       = owner_q;
        opcode_d      = opcode_q;
        op_0_d        = op_0_q;
        op_1_d        = op_1_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    opcode_d = req0_opcode;
                    op_0_d   = req0_op_0;
                    op_1_d   = req0_op_1;
                    owner_d  = 1'b0;
                    state_d  = ST_EXEC;
                end else if (grant1) begin
                    opcode_d = req1_opcode;
                    op_0_d   = req1_op_0;
                    op_1_d   = req1_op_1;
                    owner_d  = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Capture straight into the owner's response registers; the
                // other port keeps presenting whatever it last returned.
                if (owner_q) begin
                    rsp1_result_d = alu_result;
                    rsp1_zero_d   = alu_zero_f;
                end else begin
                    rsp0_result_d = alu_result;
                    rsp0_zero_d   = alu_zero_f;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    last_id_d = owner_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_opcode = '0;
        alu_op_0   = '0;
        alu_op_1   = '0;
        busy       = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                // resetn gating keeps ready low for the whole reset pulse,
                // not just until the state register has been cleared.
                req0_ready = resetn && grant0;
                req1_ready = resetn && grant1;
            end
            ST_EXEC: begin
                alu_opcode = opcode_q;
                alu_op_0   = op_0_q;
                alu_op_1   = op_1_q;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: doc/alu_arb_ctrl.md
Name: alu_arb_ctrl

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-bit combinational ALU (one-hot 7-bit opcode, op_0/op_1 operands, result plus zero flag).
- Accepts one command at a time over a valid/ready request channel, drives the ALU from registered operands, and captures result and zero flag.
- Returns the response to the originating requester over a valid/ready response channel.
- Sits between two client engines and the single ALU instance.

Parameters:
- DW, 8, operand/result width; must match the ALU datapath.
- OPW, 7, opcode width; one-hot encoding, ADD=bit0, SUB=bit1, shift-left=bit2, shift-right=bit3, OR=bit4, AND=bit5, XOR=bit6.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_opcode  in  OPW  requester 0 one-hot opcode.
- req0_op_0  in  DW  requester 0 operand 0.
- req0_op_1  in  DW  requester 0 operand 1.
- req1_valid, req1_ready, req1_opcode, req1_op_0, req1_op_1: same as requester 0, for requester 1.
- rsp0_valid  out  1  response for requester 0 valid.
- rsp0_ready  in  1  requester 0 takes the response.
- rsp0_result  out  DW  ALU result for requester 0.
- rsp0_zero  out  1  ALU zero flag for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as requester 0, for requester 1.
- alu_opcode  out  OPW  to ALU opcode.
- alu_op_0  out  DW  to ALU op_0.
- alu_op_1  out  DW  to ALU op_1.
- alu_result  in  DW  from ALU result.
- alu_zero_f  in  1  from ALU zero_f.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP; reset state is IDLE.

Reset (resetn low, asynchronous):
- state=IDLE, last_id=1, so requester 0 wins the first tie.
- Operand, opcode, result and zero registers cleared to 0; owner id cleared to 0.
- Outputs during and after reset: rsp*_valid=0, rsp*_result=0, rsp*_zero=0, alu_opcode=0, alu_op_0=0, alu_op_1=0, busy=0.
- req*_ready=0 while resetn is low.
- Reset mid-operation aborts the operation; the pending response is discarded and never presented.

Arbitration (IDLE only, combinational):
- Only req0_valid high: grant 0. Only req1_valid high: grant 1.
- Both high: grant the id != last_id.
- Neither high: no grant.
- reqN_ready = (state==IDLE) && granted==N. At most one ready is high per cycle, and never outside IDLE.

IDLE:
- On reqN_valid && reqN_ready: latch opcode/op_0/op_1 and owner=N, then go to EXEC.
- Requesters may change or drop valid before acceptance; the grant is re-evaluated every IDLE cycle.

EXEC (exactly 1 cycle):
- alu_opcode/alu_op_0/alu_op_1 = latched values. In all other states these outputs are 0.
- At the end of the cycle, capture alu_result and alu_zero_f, then go to RESP.

RESP:
- rsp<owner>_valid=1; the other rsp valid stays 0.
- rsp<owner>_result/zero = captured values. The non-owner response outputs hold their last values.
- Hold until rsp<owner>_ready=1. On that edge: go to IDLE, set last_id=owner, deassert valid.
- rsp_ready on the non-owner port is ignored.

Timing:
- Accept at edge k, capture at edge k+1, rsp_valid high after edge k+1, i.e. visible in cycle k+2.
- Minimum initiation interval is 3 cycles with rsp_ready tied high.
- No new request is accepted before the response completes.

Opcode handling:
- Non-one-hot or zero opcodes are forwarded unchanged. The ALU returns 0 for them, so the response is result=0, zero=1; no error is flagged.

Arithmetic:
- All wrap-around and shift semantics belong to the ALU and are passed through unmodified.
- ADD/SUB wrap modulo 2^DW.

Test Plan:
- Single request: req0 ADD (0000001), op_0=8'hF0, op_1=8'h20, rsp0_ready=1 -> rsp0_valid exactly 2 cycles after acceptance; rsp0_result=8'h10, rsp0_zero=0; rsp1_valid stays 0.
- Contention: both valid from reset, req0 SUB 5-5, req1 XOR 8'hAA^8'h55 -> req0 served first (result 0, zero=1), then req1 (result 8'hFF, zero=0); then both again -> req0 served next.
- Back-pressure: req1 AND 8'h0F&8'h3C with rsp1_ready low for 5 cycles -> rsp1_valid held with result 8'h0C stable; req0_ready stays 0 throughout; IDLE is re-entered only on the rsp1_ready edge.
- Shift and invalid opcode: opcode bit2, op_0=8'h81, op_1=1 -> 8'h02. Opcode 0000011 -> result 0, zero=1.
- Reset mid-op: assert resetn low during EXEC -> busy=0, rsp*_valid=0 immediately and asynchronously. After release, a new req0 OR 8'h01|8'h80 -> 8'h81, and no stale response appears.
- Saturation: both requesters valid continuously for 20 operations with rsp ready high -> strict alternation 0,1,0,1…; an accept every 3 cycles; no response ever goes to the wrong port.
